// File: rtl/sink_if.sv
// sink_if: symbol-in / bit-out handshake bundle for the sink decoder.
//   sym[1:0], sym_valid, sym_ready : encoded symbol stream (producer -> sink)
//   bit_o, bit_valid, bit_ready    : decoded bit stream (sink -> consumer)
//   pending, err, err_cnt[7:0]     : decoder status
// Modport slave is the decoder side, modport master the environment side.
interface sink_if;
  logic [1:0] sym;
  logic       sym_valid;
  logic       sym_ready;
  logic       bit_o;
  logic       bit_valid;
  logic       bit_ready;
  logic       pending;
  logic       err;
  logic [7:0] err_cnt;

  modport master (
    output sym, sym_valid, bit_ready,
    input  sym_ready, bit_o, bit_valid, pending, err, err_cnt
  );

  modport slave (
    input  sym, sym_valid, bit_ready,
    output sym_ready, bit_o, bit_valid, pending, err, err_cnt
  );
endinterface

// File: rtl/sink.sv
// sink: decoder for the 2-bit symbol stream of the 3-state Mealy source
// encoder. Tracks the encoder state, holds one bit unresolved (PEND) when
// the symbol 10 is received in S10, flags illegal symbols and delivers
// decoded bits through a FIFO_DEPTH-entry output FIFO.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   bus.slave  sym/sym_valid/sym_ready in, bit_o/bit_valid/bit_ready out,
//              pending, err (one-cycle pulse), err_cnt[7:0]
// Optional feature: define SINK_ERR_CNT_EN for a saturating 8-bit count of
// illegal symbols on err_cnt; otherwise err_cnt is tied to zero.
module sink #(
  parameter int FIFO_DEPTH = 4
) (
  input logic   clk,
  input logic   rst,
  sink_if.slave bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  // Accepting a symbol can push two bits, so keep two free entries.
  localparam logic [CW-1:0] READY_MAX = CW'(FIFO_DEPTH - 2);

  localparam logic [1:0] S00  = 2'd0;
  localparam logic [1:0] S10  = 2'd1;
  localparam logic [1:0] S11  = 2'd2;
  localparam logic [1:0] PEND = 2'd3;

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic [1:0]            n_emit_s;
  logic                  emit0_s;
  logic                  emit1_s;
  logic                  err_s;
  logic                  accept_s;
  logic                  pop_s;
  logic [FIFO_DEPTH-1:0] mem_r;
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         wr_ptr_inc_s;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_nxt_s;
  logic                  sym_ready_r;
  logic                  bit_valid_r;
  logic                  err_r;

  assign accept_s     = bus.sym_valid & sym_ready_r;
  assign pop_s        = bit_valid_r & bus.bit_ready;
  assign wr_ptr_inc_s = wr_ptr_r + AW'(1'b1);
  assign count_nxt_s  = count_r + CW'(n_emit_s) - CW'(pop_s);

  // Symbol decode: next state, bits emitted (in order) and illegal-symbol flag
  always_comb begin
    state_nxt_s = state_r;
    n_emit_s    = 2'd0;
    emit0_s     = 1'b0;
    emit1_s     = 1'b0;
    err_s       = 1'b0;
    if (accept_s) begin
      case (state_r)
        S00: begin
          case (bus.sym)
            2'b10:   begin n_emit_s = 2'd1; emit0_s = 1'b0; state_nxt_s = S10; end
            2'b11:   begin n_emit_s = 2'd1; emit0_s = 1'b1; state_nxt_s = S00; end
            default: err_s = 1'b1;
          endcase
        end
        S10: begin
          // 10 from S10 is either x=0 (stay S10) or x=1 (go S11): defer.
          case (bus.sym)
            2'b10:   state_nxt_s = PEND;
            default: err_s = 1'b1;
          endcase
        end
        S11: begin
          case (bus.sym)
            2'b11:   begin n_emit_s = 2'd1; emit0_s = 1'b0; state_nxt_s = S10; end
            2'b01:   begin n_emit_s = 2'd1; emit0_s = 1'b1; state_nxt_s = S11; end
            default: err_s = 1'b1;
          endcase
        end
        PEND: begin
          // Encoder is in S10 or S11; only S10 can emit 10, only S11 can
          // emit 11/01, which resolves the held bit.
          case (bus.sym)
            2'b10:   begin n_emit_s = 2'd1; emit0_s = 1'b0; state_nxt_s = PEND; end
            2'b11:   begin n_emit_s = 2'd2; emit0_s = 1'b1; emit1_s = 1'b0; state_nxt_s = S10; end
            2'b01:   begin n_emit_s = 2'd2; emit0_s = 1'b1; emit1_s = 1'b1; state_nxt_s = S11; end
            default: err_s = 1'b1;
          endcase
        end
        default: state_nxt_s = S00;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Decoder state, FIFO occupancy and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S00;
      count_r     <= {CW{1'b0}};
      sym_ready_r <= 1'b1;
      bit_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      count_r     <= count_nxt_s;
      sym_ready_r <= (count_nxt_s <= READY_MAX);
      bit_valid_r <= (count_nxt_s != {CW{1'b0}});
      err_r       <= err_s;
    end
  end

  // FIFO storage and pointers: up to two pushes and one pop per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r    <= {FIFO_DEPTH{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (n_emit_s != 2'd0) begin
        mem_r[wr_ptr_r] <= emit0_s;
      end else begin
        mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
      if (n_emit_s == 2'd2) begin
        mem_r[wr_ptr_inc_s] <= emit1_s;
      end else begin
        mem_r[wr_ptr_inc_s] <= mem_r[wr_ptr_inc_s];
      end
      wr_ptr_r <= wr_ptr_r + AW'(n_emit_s);
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

`ifdef SINK_ERR_CNT_EN
  logic [7:0] err_cnt_r;

  // Saturating illegal-symbol counter, updated together with the err pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_r <= 8'd0;
    end else if (err_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign bus.err_cnt = err_cnt_r;
`else
  assign bus.err_cnt = 8'd0;
`endif

  assign bus.sym_ready = sym_ready_r;
  assign bus.bit_valid = bit_valid_r;
  assign bus.bit_o     = mem_r[rd_ptr_r];
  assign bus.pending   = (state_r == PEND);
  assign bus.err       = err_r;

endmodule

// File: tb/tb_sink.sv
// tb_sink: self-checking bench for sink (FIFO_DEPTH 4). Expected bits are
// queued when symbols are driven and compared as the DUT pops them.
module tb_sink;

`ifdef SINK_ERR_CNT_EN
  localparam bit ERR_CNT_ON = 1'b1;
`else
  localparam bit ERR_CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   exp_q[$];

  sink_if bus ();

  sink #(.FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Encoder reference: returns {symbol, next_state}
  function automatic logic [3:0] enc(input logic [1:0] st, input logic x);
    case (st)
      2'b00:   return x ? {2'b11, 2'b00} : {2'b10, 2'b10};
      2'b10:   return x ? {2'b10, 2'b11} : {2'b10, 2'b10};
      2'b11:   return x ? {2'b01, 2'b11} : {2'b11, 2'b10};
      default: return 4'b0000;
    endcase
  endfunction

  // Scoreboard: each popped bit must equal the oldest expected bit
  always @(negedge clk) begin
    bit e;
    #1;
    if (!rst && bus.bit_valid && bus.bit_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL extra_bit: got %0b, expected no bit", bus.bit_o);
      end else begin
        e = exp_q.pop_front();
        if (bus.bit_o !== e) begin
          n_bad++;
          $display("FAIL bit_order: got %0b, expected %0b", bus.bit_o, e);
        end
      end
    end
  end

  // Present one symbol, return once accepted (at negedge of the next cycle)
  task automatic send(input logic [1:0] s, output int waited);
    waited = 0;
    bus.sym = s;
    bus.sym_valid = 1'b1;
    while (!bus.sym_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (!bus.sym_ready) begin
      n_bad++;
      $display("FAIL send_timeout: sym_ready=%0b after %0d cycles, expected 1", bus.sym_ready, waited);
      bus.sym_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int guard = 0;
    bus.sym_valid = 1'b0;
    bus.bit_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.bit_valid) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || bus.bit_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain: %0d bits outstanding, bit_valid=%0b, expected 0/0", exp_q.size(), bus.bit_valid);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.sym_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp += 6;
    if (bus.sym_ready !== 1'b1) begin n_bad++; $display("FAIL rst_sym_ready: got %0b, expected 1", bus.sym_ready); end
    if (bus.bit_valid !== 1'b0) begin n_bad++; $display("FAIL rst_bit_valid: got %0b, expected 0", bus.bit_valid); end
    if (bus.bit_o !== 1'b0) begin n_bad++; $display("FAIL rst_bit_o: got %0b, expected 0", bus.bit_o); end
    if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL rst_pending: got %0b, expected 0", bus.pending); end
    if (bus.err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %0b, expected 0", bus.err); end
    if (bus.err_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_err_cnt: got %0d, expected 0", bus.err_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_encoder_seq();
    logic       xs[5]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       pend[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] st = 2'b00;
    logic [3:0] r;
    int         w;
    apply_reset();
    bus.bit_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r  = enc(st, xs[i]);
      st = r[1:0];
      exp_q.push_back(xs[i]);
      send(r[3:2], w);
      n_cmp++;
      if (bus.pending !== pend[i]) begin
        n_bad++;
        $display("FAIL enc_pending[%0d]: got %0b, expected %0b", i, bus.pending, pend[i]);
      end
    end
    drain();
  endtask

  task automatic test_error();
    int w;
    apply_reset();
    bus.bit_ready = 1'b1;
    send(2'b01, w);
    n_cmp += 4;
    if (bus.err !== 1'b1) begin n_bad++; $display("FAIL err_pulse: got %0b, expected 1", bus.err); end
    if (bus.bit_valid !== 1'b0) begin n_bad++; $display("FAIL err_no_bit: got %0b, expected 0", bus.bit_valid); end
    if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL err_pending: got %0b, expected 0", bus.pending); end
    if (bus.err_cnt !== (ERR_CNT_ON ? 8'd1 : 8'd0)) begin
      n_bad++; $display("FAIL err_cnt_one: got %0d, expected %0d", bus.err_cnt, ERR_CNT_ON ? 1 : 0);
    end
    bus.sym_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.err !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle: got %0b, expected 0", bus.err); end
    exp_q.push_back(1'b1);
    send(2'b11, w);
    n_cmp++;
    if (bus.err !== 1'b0) begin n_bad++; $display("FAIL err_after_legal: got %0b, expected 0", bus.err); end
    drain();
  endtask

  task automatic test_s10_illegal();
    int w;
    apply_reset();
    bus.bit_ready = 1'b1;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    send(2'b10, w);
    send(2'b10, w);
    send(2'b11, w);
    send(2'b11, w);
    n_cmp += 2;
    if (bus.err !== 1'b1) begin n_bad++; $display("FAIL s10_err: got %0b, expected 1", bus.err); end
    if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL s10_pending: got %0b, expected 0", bus.pending); end
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    apply_reset();
    // Throughput: with the consumer always ready, one symbol per cycle.
    bus.bit_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(1'b1);
      send(2'b11, w);
      n_cmp++;
      if (w != 0) begin n_bad++; $display("FAIL b2b_stall[%0d]: waited %0d cycles, expected 0", i, w); end
    end
    drain();
    // Backpressure: three bits fill the FIFO to the stall threshold.
    bus.bit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(1'b1);
      send(2'b11, w);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp += 2;
      if (bus.sym_ready !== 1'b0) begin n_bad++; $display("FAIL bp_sym_ready[%0d]: got %0b, expected 0", i, bus.sym_ready); end
      if (bus.bit_valid !== 1'b1) begin n_bad++; $display("FAIL bp_bit_valid[%0d]: got %0b, expected 1", i, bus.bit_valid); end
      @(negedge clk);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int w;
    apply_reset();
    bus.bit_ready = 1'b0;
    send(2'b10, w);
    send(2'b10, w);
    send(2'b10, w);
    n_cmp += 2;
    if (bus.pending !== 1'b1) begin n_bad++; $display("FAIL mid_pending: got %0b, expected 1", bus.pending); end
    if (bus.bit_valid !== 1'b1) begin n_bad++; $display("FAIL mid_bit_valid: got %0b, expected 1", bus.bit_valid); end
    // Reset while a legal symbol is offered: reset must win.
    rst = 1'b1;
    bus.sym = 2'b11;
    bus.sym_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.sym_valid = 1'b0;
    exp_q.delete();
    n_cmp += 4;
    if (bus.bit_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_bit_valid: got %0b, expected 0", bus.bit_valid); end
    if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL mid_rst_pending: got %0b, expected 0", bus.pending); end
    if (bus.sym_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_sym_ready: got %0b, expected 1", bus.sym_ready); end
    if (bus.err !== 1'b0) begin n_bad++; $display("FAIL mid_rst_err: got %0b, expected 0", bus.err); end
    exp_q.push_back(1'b1);
    send(2'b11, w);
    drain();
  endtask

  task automatic test_err_saturate();
    int w;
    apply_reset();
    bus.bit_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(2'b00, w);
    end
    n_cmp += 3;
    if (bus.err !== 1'b1) begin n_bad++; $display("FAIL sat_err: got %0b, expected 1", bus.err); end
    if (bus.bit_valid !== 1'b0) begin n_bad++; $display("FAIL sat_no_bit: got %0b, expected 0", bus.bit_valid); end
    if (bus.err_cnt !== (ERR_CNT_ON ? 8'd255 : 8'd0)) begin
      n_bad++; $display("FAIL sat_err_cnt: got %0d, expected %0d", bus.err_cnt, ERR_CNT_ON ? 255 : 0);
    end
    drain();
  endtask

  initial begin
    bus.sym       = 2'b00;
    bus.sym_valid = 1'b0;
    bus.bit_ready = 1'b0;
    test_reset();
    test_encoder_seq();
    test_error();
    test_s10_illegal();
    test_back_to_back();
    test_reset_mid();
    test_err_saturate();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sink.md
# sink

Receive-side decoder for the 2-bit symbol stream produced by the team's 3-state Mealy `source` encoder; recovers the original 1-bit input sequence. Tracks the encoder's state, uses one symbol of lookahead to resolve the one ambiguous transition, flags illegal symbols, and delivers decoded bits through a small output FIFO with valid/ready handshakes on both sides. Sits directly downstream of the encoder's symbol output in the experiment datapath.

## Interface
- FIFO_DEPTH, 4, output bit FIFO entries; power of two, >= 2
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- sym  input  2  encoded symbol
- sym_valid  input  1  symbol present
- sym_ready  output  1  symbol accepted when sym_valid & sym_ready
- bit_o  output  1  decoded bit, FIFO head
- bit_valid  output  1  FIFO non-empty
- bit_ready  input  1  consumer pops head when bit_valid & bit_ready
- pending  output  1  one decoded bit held unresolved (state PEND)
- err  output  1  one-cycle pulse: illegal symbol received
- err_cnt  output  8  illegal-symbol count (see Configuration)

## Operation
- Encoder map (state, x -> y, next): 00: 0->10,10; 1->11,00. 10: 0->10,10; 1->10,11. 11: 0->11,10; 1->01,11.
- Decoder states: S00, S10, S11, PEND (was S10, got 10, bit unknown; encoder now 10 or 11).
- Transitions per accepted symbol (emitted bits in order):
  - S00: 10 -> emit 0, S10; 11 -> emit 1, S00; 00/01 -> error.
  - S10: 10 -> emit none, PEND; others -> error.
  - S11: 11 -> emit 0, S10; 01 -> emit 1, S11; 10 -> emit 0, S10 is NOT legal (10 only reachable from 00/10); 10/00 -> error.
  - PEND: 10 -> emit 0, stay PEND; 11 -> emit 1,0, S10; 01 -> emit 1,1, S11; 00 -> error.
- Error: symbol consumed, nothing emitted, state unchanged, err pulses.
- pending = (state == PEND).
- FIFO: up to 2 pushes and 1 pop per cycle; push order = emission order; pop of head same cycle as push legal.
- sym_ready = (count <= FIFO_DEPTH-2), from registered count; guarantees room for worst-case 2 bits.
- No overflow possible; underflow impossible (pop gated by bit_valid).

## Timing
- Reset values: state S00, FIFO empty, sym_ready 1, bit_valid 0, bit_o 0, pending 0, err 0, err_cnt 0.
- Symbol accepted at edge t: bits in FIFO and bit_valid high after edge t (visible cycle t+1); err high cycle t+1 only.
- Throughput: one symbol/cycle while bit_ready held high; sustained 2-bit emissions stall input via sym_ready.
- bit_o/bit_valid depend only on registers; no combinational path sym -> bit_o.
- rst mid-operation (incl. PEND, full FIFO): all state cleared next edge; unresolved bit discarded; no err.
- rst has priority over any handshake in same cycle.

## Configuration
- SINK_ERR_CNT_EN defined: err_cnt is an 8-bit counter incremented on each err pulse, saturates at 255, cleared only by rst.
- Undefined: counter logic absent, err_cnt tied to 8'd0; err pulse unaffected.

## Test plan
- Encoder x=1,0,0,1,1 from reset -> symbols 11,10,10,10,01 -> bits 1,0,0,1,1; pending high after 3rd and 4th symbols, low after 5th.
- From reset send 01 -> err pulse 1 cycle, no bit, state S00, err_cnt 1 (macro on) / 0 (off); then 11 -> bit 1.
- Symbols 10,10,11 from reset -> bits 0,1,0, ends S10; next 11 -> err (S10 accepts only 10).
- bit_ready=0, stream 11 repeatedly -> 3 bits accepted, sym_ready low at count 3 (DEPTH 4); release -> bits drain in order, no loss.
- Drive rst while pending=1 and FIFO holding 2 bits -> next cycle bit_valid 0, pending 0, sym_ready 1; 11 then decodes to 1.
- 300 illegal symbols with SINK_ERR_CNT_EN -> err_cnt saturates at 255.
